tlb_search_stage: RTL and testbench
===================================

Name: tlb_search_stage

Overview:
- 16-entry TLB tag array with a registered search stage and an INVTLB sweep engine.
- Produces the 16-bit one-hot hit vector that the downstream 16-to-4 encoder turns into a TLB index.
- Tag writes are indexed by a 4-bit index, decoded internally to per-entry enables.
- Sits between the MEM-stage address generation and the TLB index/read logic.

Parameters:
- TLBNUM, 16, number of entries; fixed at 16 to match the 4-bit index.
- VPPN_W, 19, virtual page-pair number width.
- ASID_W, 10, ASID width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous reset, active-low
- s_valid  in  1  search request valid
- s_ready  out  1  search request accepted when s_valid & s_ready
- s_vppn  in  19  search VA[31:13]
- s_asid  in  10  search ASID
- r_valid  out  1  search result valid
- r_ready  in  1  result consumed when r_valid & r_ready
- r_hit_vec  out  16  per-entry match, registered
- r_hit  out  1  OR of r_hit_vec
- r_multi  out  1  more than one bit of r_hit_vec set
- we  in  1  tag write enable
- w_index  in  4  entry to write
- w_e  in  1  write value: entry valid
- w_g  in  1  write value: global
- w_ps  in  6  write value: page size
- w_asid  in  10  write value: ASID
- w_vppn  in  19  write value: VPPN
- inv_valid  in  1  start INVTLB sweep
- inv_op  in  5  INVTLB op code
- inv_asid  in  10  INVTLB ASID operand
- inv_vppn  in  19  INVTLB VPPN operand
- inv_busy  out  1  sweep in progress
- inv_done  out  1  one-cycle pulse when sweep ends

Behaviour:
- Reset (resetn=0 at posedge): all E bits=0, r_valid=0, r_hit_vec=0, r_hit=0, r_multi=0, FSM=IDLE, inv_busy=0, inv_done=0. Reset mid-sweep or mid-result aborts immediately; no inv_done is issued.
- Entry match: E & (G | asid==s_asid) & vppn compare.
  - ps==21: compare vppn[18:9] only.
  - Any other ps: compare all 19 bits.
- Search:
  - s_ready = (FSM==IDLE) & (!r_valid | r_ready).
  - On accept at edge N, compare combinationally against current tags and register the result; r_valid=1 after edge N. Latency is 1 cycle.
  - Back-to-back accepts are allowed while r_ready=1.
  - While r_valid & !r_ready, r_hit_vec/r_hit/r_multi hold stable.
  - r_valid clears on consume with no new accept.
- Write/search collision: a write and an accepted search in the same cycle; the search sees the pre-write tags. The write takes effect after the edge.
- Tag write: on we, all fields of entry w_index are written at the edge. we is legal in every FSM state.
- FSM:
  - IDLE: inv_valid & s_ready-condition -> SWEEP with idx=0. In the same cycle s_valid is not accepted, because inv_valid has priority and s_ready is forced low when inv_valid=1.
  - SWEEP: each cycle, evaluate entry idx against inv_op and clear its E on match. idx increments; after idx=15 go to DONE. inv_busy=1 and s_ready=0 throughout.
  - DONE: inv_done=1 for one cycle, then IDLE.
  - Sweep takes 16 cycles; inv_valid outside IDLE is ignored.
- INVTLB op match conditions:
  - op 0, 1: all entries.
  - op 2: G=1.
  - op 3: G=0.
  - op 4: G=0 & asid==inv_asid.
  - op 5: G=0 & asid==inv_asid & vppn match.
  - op 6: (G=1 | asid==inv_asid) & vppn match.
  - op ≥7: no entry cleared; sweep and inv_done still occur.
  - vppn match uses the same ps rule as search.
- Write vs sweep on the same entry in the same cycle: the write wins.
- A pending result is unaffected by the sweep.

Decomposition:
- Shared header tlb_defs.vh holds:
  - PS_4K=6'd12, PS_4M=6'd21.
  - INVTLB op codes 0–6.
  - FSM state encodings IDLE/SWEEP/DONE.
  - Tag field widths.
- Sub-module tlb_entry_match: one entry's combinational compare, with outputs search_hit and inv_hit. Instantiated 16 times via generate.

Test Plan:
- Reset, then write idx3 {E=1,G=0,ps=12,asid=5,vppn=0x12345}; search vppn=0x12345 asid=5 -> next cycle r_hit_vec=0x0008, r_hit=1, r_multi=0. Search with asid=6 -> r_hit_vec=0.
- Write idx7 {ps=21,G=1,vppn=0x12200}; search vppn=0x123FF asid=9 -> r_hit_vec=0x0080. Also write idx8 with the same vppn/ps -> r_hit_vec=0x0180, r_multi=1.
- Hold r_ready=0 with r_valid=1 for 3 cycles -> s_ready=0, result stable. Then r_ready=1 with s_valid=1 -> consume and new accept in the same cycle.
- Search accepted in the same cycle as a write of E=0 to the hit entry -> result still hits. The next search misses.
- Entries 0–15 all valid, G alternating; inv_op=2 -> inv_busy high 16 cycles, inv_done pulse on cycle 17, s_ready=0 throughout, only G=0 entries remain valid.
- Start inv_op=0, assert resetn=0 at sweep cycle 5 -> all outputs at reset values, no inv_done pulse.

Source files
------------

// File: rtl/tlb_search_stage_pkg.sv
// Shared TLB definitions: field widths, page sizes, INVTLB op codes, sweep FSM encodings.
package tlb_search_stage_pkg;

    localparam int TLBNUM = 16;
    localparam int IDX_W  = 4;
    localparam int VPPN_W = 19;
    localparam int ASID_W = 10;
    localparam int PS_W   = 6;

    localparam logic [PS_W-1:0] PS_4K = 6'd12;
    localparam logic [PS_W-1:0] PS_4M = 6'd21;

    localparam logic [4:0] INV_ALL0      = 5'd0;
    localparam logic [4:0] INV_ALL1      = 5'd1;
    localparam logic [4:0] INV_GLOBAL    = 5'd2;
    localparam logic [4:0] INV_NONGLOBAL = 5'd3;
    localparam logic [4:0] INV_ASID      = 5'd4;
    localparam logic [4:0] INV_ASID_VA   = 5'd5;
    localparam logic [4:0] INV_GA_VA     = 5'd6;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef struct packed {
        logic              e;
        logic              g;
        logic [PS_W-1:0]   ps;
        logic [ASID_W-1:0] asid;
        logic [VPPN_W-1:0] vppn;
    } tag_t;

    // A 4M entry covers a whole VPPN pair-block, so only the upper 10 bits take part.
    function automatic logic vppn_match(input logic [VPPN_W-1:0] tag_vppn,
                                        input logic [PS_W-1:0]   ps,
                                        input logic [VPPN_W-1:0] q_vppn);
        if (ps == PS_4M)
            return tag_vppn[18:9] == q_vppn[18:9];
        return tag_vppn == q_vppn;
    endfunction

endpackage

// File: rtl/tlb_search_stage_entry_match.sv
// Combinational compare of one TLB entry against the search key and the INVTLB operands.
module tlb_entry_match
    import tlb_search_stage_pkg::*;
(
    input  tag_t              tag,
    input  logic [VPPN_W-1:0] s_vppn,
    input  logic [ASID_W-1:0] s_asid,
    input  logic [4:0]        inv_op,
    input  logic [ASID_W-1:0] inv_asid,
    input  logic [VPPN_W-1:0] inv_vppn,
    output logic              search_hit,
    output logic              inv_hit
);

    logic inv_asid_eq;
    logic inv_va_eq;

    assign search_hit  = tag.e & (tag.g | (tag.asid == s_asid))
                       & vppn_match(tag.vppn, tag.ps, s_vppn);
    assign inv_asid_eq = (tag.asid == inv_asid);
    assign inv_va_eq   = vppn_match(tag.vppn, tag.ps, inv_vppn);

    always_comb begin
        inv_hit = 1'b0;
        case (inv_op)
            INV_ALL0, INV_ALL1: inv_hit = 1'b1;
            INV_GLOBAL:         inv_hit = tag.g;
            INV_NONGLOBAL:      inv_hit = ~tag.g;
            INV_ASID:           inv_hit = ~tag.g & inv_asid_eq;
            INV_ASID_VA:        inv_hit = ~tag.g & inv_asid_eq & inv_va_eq;
            INV_GA_VA:          inv_hit = (tag.g | inv_asid_eq) & inv_va_eq;
            default:            inv_hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/tlb_search_stage.sv
// 16-entry TLB tag array with a one-cycle registered search and an INVTLB sweep engine.
//   state | meaning
//   IDLE  | searches accepted, waiting for inv_valid
//   SWEEP | walking entries 0..15, clearing E on INVTLB match
//   DONE  | one-cycle inv_done pulse
module tlb_search_stage
    import tlb_search_stage_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [VPPN_W-1:0] s_vppn,
    input  logic [ASID_W-1:0] s_asid,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [TLBNUM-1:0] r_hit_vec,
    output logic              r_hit,
    output logic              r_multi,
    input  logic              we,
    input  logic [IDX_W-1:0]  w_index,
    input  logic              w_e,
    input  logic              w_g,
    input  logic [PS_W-1:0]   w_ps,
    input  logic [ASID_W-1:0] w_asid,
    input  logic [VPPN_W-1:0] w_vppn,
    input  logic              inv_valid,
    input  logic [4:0]        inv_op,
    input  logic [ASID_W-1:0] inv_asid,
    input  logic [VPPN_W-1:0] inv_vppn,
    output logic              inv_busy,
    output logic              inv_done
);

    tag_t              tags [TLBNUM];
    logic [1:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [TLBNUM-1:0] search_hit;
    logic [TLBNUM-1:0] inv_hit;
    logic              out_free;
    logic              accept;
    logic              start;

    for (genvar i = 0; i < TLBNUM; i++) begin : g_match
        tlb_entry_match u_match (
            .tag       (tags[i]),
            .s_vppn    (s_vppn),
            .s_asid    (s_asid),
            .inv_op    (inv_op),
            .inv_asid  (inv_asid),
            .inv_vppn  (inv_vppn),
            .search_hit(search_hit[i]),
            .inv_hit   (inv_hit[i])
        );
    end

    // inv_valid takes priority over a search offered in the same cycle.
    assign out_free = ~r_valid | r_ready;
    assign s_ready  = (state == ST_IDLE) & ~inv_valid & out_free;
    assign start    = (state == ST_IDLE) & inv_valid & out_free;
    assign accept   = s_valid & s_ready;
    assign inv_busy = (state == ST_SWEEP);
    assign inv_done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_SWEEP;
                        idx   <= '0;
                    end
                end
                ST_SWEEP: begin
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(TLBNUM - 1))
                        state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sweep clear is issued first so a same-entry write in the same cycle overrides it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < TLBNUM; i++)
                tags[i].e <= 1'b0;
        end else begin
            if (state == ST_SWEEP && inv_hit[idx])
                tags[idx].e <= 1'b0;
            if (we)
                tags[w_index] <= '{e: w_e, g: w_g, ps: w_ps, asid: w_asid, vppn: w_vppn};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid   <= 1'b0;
            r_hit_vec <= '0;
            r_hit     <= 1'b0;
            r_multi   <= 1'b0;
        end else if (accept) begin
            r_valid   <= 1'b1;
            r_hit_vec <= search_hit;
            r_hit     <= |search_hit;
            r_multi   <= |(search_hit & (search_hit - 1'b1));
        end else if (r_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tlb_search_stage.sv
// Scoreboard bench for tlb_search_stage: a tag model predicts each accepted search result.
module tb_tlb_search_stage;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [18:0] s_vppn = '0;
    logic [9:0]  s_asid = '0;
    logic        r_valid;
    logic        r_ready = 1'b1;
    logic [15:0] r_hit_vec;
    logic        r_hit;
    logic        r_multi;
    logic        we = 1'b0;
    logic [3:0]  w_index = '0;
    logic        w_e = 1'b0;
    logic        w_g = 1'b0;
    logic [5:0]  w_ps = '0;
    logic [9:0]  w_asid = '0;
    logic [18:0] w_vppn = '0;
    logic        inv_valid = 1'b0;
    logic [4:0]  inv_op = '0;
    logic [9:0]  inv_asid = '0;
    logic [18:0] inv_vppn = '0;
    logic        inv_busy;
    logic        inv_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic        m_e    [16];
    logic        m_g    [16];
    logic [5:0]  m_ps   [16];
    logic [9:0]  m_asid [16];
    logic [18:0] m_vppn [16];
    logic [15:0] sbq [$];

    always #5 clk = ~clk;

    tlb_search_stage dut (
        .clk(clk), .resetn(resetn),
        .s_valid(s_valid), .s_ready(s_ready), .s_vppn(s_vppn), .s_asid(s_asid),
        .r_valid(r_valid), .r_ready(r_ready), .r_hit_vec(r_hit_vec), .r_hit(r_hit), .r_multi(r_multi),
        .we(we), .w_index(w_index), .w_e(w_e), .w_g(w_g), .w_ps(w_ps), .w_asid(w_asid), .w_vppn(w_vppn),
        .inv_valid(inv_valid), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
        .inv_busy(inv_busy), .inv_done(inv_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic va_eq(input logic [18:0] a, input logic [5:0] ps, input logic [18:0] b);
        return (ps == 6'd21) ? (a[18:9] == b[18:9]) : (a == b);
    endfunction

    function automatic logic [15:0] model_hit(input logic [18:0] vppn, input logic [9:0] asid);
        logic [15:0] v = '0;
        for (int i = 0; i < 16; i++)
            v[i] = m_e[i] & (m_g[i] | (m_asid[i] == asid)) & va_eq(m_vppn[i], m_ps[i], vppn);
        return v;
    endfunction

    task automatic model_inv(input logic [4:0] op);
        logic hit;
        for (int i = 0; i < 16; i++) begin
            case (op)
                5'd0, 5'd1: hit = 1'b1;
                5'd2:       hit = m_g[i];
                5'd3:       hit = !m_g[i];
                5'd4:       hit = !m_g[i] && m_asid[i] == inv_asid;
                5'd5:       hit = !m_g[i] && m_asid[i] == inv_asid && va_eq(m_vppn[i], m_ps[i], inv_vppn);
                5'd6:       hit = (m_g[i] || m_asid[i] == inv_asid) && va_eq(m_vppn[i], m_ps[i], inv_vppn);
                default:    hit = 1'b0;
            endcase
            if (hit) m_e[i] = 1'b0;
        end
    endtask

    // One clock: handshakes are judged mid-cycle, then we return 1 time unit past the edge.
    task automatic cyc();
        logic [15:0] want;
        @(negedge clk);
        if (!resetn) begin
            sbq.delete();
            for (int i = 0; i < 16; i++) m_e[i] = 1'b0;
        end else begin
            if (r_valid && r_ready) begin
                if (sbq.size() == 0) begin
                    check("sb_underflow", sbq.size(), 1);
                end else begin
                    want = sbq.pop_front();
                    check("r_hit_vec", r_hit_vec, want);
                    check("r_hit", r_hit, |want);
                    check("r_multi", r_multi, $countones(want) > 1);
                end
            end
            if (s_valid && s_ready)
                sbq.push_back(model_hit(s_vppn, s_asid));
            if (we) begin
                m_e[w_index] = w_e;   m_g[w_index] = w_g;   m_ps[w_index] = w_ps;
                m_asid[w_index] = w_asid; m_vppn[w_index] = w_vppn;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input logic e, input logic g, input logic [5:0] ps,
                      input logic [9:0] asid, input logic [18:0] vppn);
        we = 1'b1; w_index = 4'(idx); w_e = e; w_g = g; w_ps = ps; w_asid = asid; w_vppn = vppn;
        cyc();
        we = 1'b0;
    endtask

    task automatic search(input logic [18:0] vppn, input logic [9:0] asid);
        s_valid = 1'b1; s_vppn = vppn; s_asid = asid;
        cyc();
        s_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_r_valid"}, r_valid, 0);
        check({pfx, "_r_hit_vec"}, r_hit_vec, 0);
        check({pfx, "_r_hit"}, r_hit, 0);
        check({pfx, "_r_multi"}, r_multi, 0);
        check({pfx, "_inv_busy"}, inv_busy, 0);
        check({pfx, "_inv_done"}, inv_done, 0);
        check({pfx, "_s_ready"}, s_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        logic seen_done;
        for (int i = 0; i < 16; i++) begin
            m_e[i] = 1'b0; m_g[i] = 1'b0; m_ps[i] = '0; m_asid[i] = '0; m_vppn[i] = '0;
        end

        resetn = 1'b0;
        cyc(); cyc();
        resetn = 1'b1;
        check_reset_outputs("reset");

        // Basic hit, then ASID miss back-to-back.
        wr(3, 1'b1, 1'b0, 6'd12, 10'd5, 19'h12345);
        s_valid = 1'b1; s_vppn = 19'h12345; s_asid = 10'd5;
        cyc();
        s_asid = 10'd6;
        cyc();
        s_valid = 1'b0;
        cyc();

        // 4M global entry, then a duplicate giving a multi-hit.
        wr(7, 1'b1, 1'b1, 6'd21, 10'd0, 19'h12200);
        search(19'h123FF, 10'd9);
        wr(8, 1'b1, 1'b1, 6'd21, 10'd0, 19'h12200);
        search(19'h123FF, 10'd9);
        cyc();

        // Back-pressure: result held for 3 cycles, then consume + accept together.
        r_ready = 1'b0;
        search(19'h12345, 10'd5);
        for (int k = 0; k < 3; k++) begin
            check("stall_s_ready", s_ready, 0);
            check("stall_r_valid", r_valid, 1);
            check("stall_vec", r_hit_vec, sbq[0]);
            cyc();
        end
        r_ready = 1'b1;
        s_valid = 1'b1; s_vppn = 19'h12200; s_asid = 10'd9;
        #1;
        check("consume_accept_s_ready", s_ready, 1);
        cyc();
        s_valid = 1'b0;
        cyc();

        // Search and invalidating write to the hit entry in the same cycle.
        s_valid = 1'b1; s_vppn = 19'h12345; s_asid = 10'd5;
        we = 1'b1; w_index = 4'd3; w_e = 1'b0; w_g = 1'b0; w_ps = 6'd12; w_asid = 10'd5; w_vppn = 19'h12345;
        cyc();
        we = 1'b0;
        cyc();
        s_valid = 1'b0;
        cyc();

        // Fill all entries with G alternating, sweep with op 2 (clear globals).
        for (int i = 0; i < 16; i++)
            wr(i, 1'b1, i[0], 6'd12, 10'(i), 19'(i * 256));
        inv_valid = 1'b1; inv_op = 5'd2;
        s_valid = 1'b1; s_vppn = 19'h0; s_asid = 10'd0;
        #1;
        check("inv_start_s_ready", s_ready, 0);
        cyc();
        inv_valid = 1'b0; s_valid = 1'b0;
        model_inv(5'd2);
        for (int k = 0; k < 16; k++) begin
            check("sweep_busy", inv_busy, 1);
            check("sweep_s_ready", s_ready, 0);
            check("sweep_done_early", inv_done, 0);
            cyc();
        end
        check("sweep_done_pulse", inv_done, 1);
        check("sweep_busy_end", inv_busy, 0);
        cyc();
        check("sweep_done_clear", inv_done, 0);
        check("sweep_idle_s_ready", s_ready, 1);
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1; s_vppn = 19'(i * 256); s_asid = 10'(i);
            cyc();
        end
        s_valid = 1'b0;
        cyc();

        // Reset during a sweep aborts it without a done pulse.
        inv_valid = 1'b1; inv_op = 5'd0;
        cyc();
        inv_valid = 1'b0;
        for (int k = 0; k < 5; k++) cyc();
        check("abort_busy_before", inv_busy, 1);
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        check_reset_outputs("abort");
        seen_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            seen_done |= inv_done;
            cyc();
        end
        check("abort_no_done", seen_done, 0);
        search(19'h00200, 10'd2);
        cyc();

        check("sb_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
